// File: rtl/sdf_butterfly_stage_if.sv
// Stream bundle between an R2SDF butterfly stage, its upstream source and the
// shared twiddle ROM.
interface sdf_butterfly_stage_if #(
   parameter int WIDTH = 17,
   parameter int TW_W  = 12
);
   // in_valid qualifies in_r/in_i for one cycle and there is no back-pressure:
   // every cycle with in_valid high is an accepted sample. out_valid qualifies
   // out_r/out_i the same way. tw_r/tw_i answer tw_idx within the same cycle.
   logic                    in_valid;
   logic signed [WIDTH-1:0] in_r;
   logic signed [WIDTH-1:0] in_i;
   logic        [3:0]       tw_idx;
   logic signed [TW_W-1:0]  tw_r;
   logic signed [TW_W-1:0]  tw_i;
   logic                    out_valid;
   logic signed [WIDTH-1:0] out_r;
   logic signed [WIDTH-1:0] out_i;

   modport master (
      output in_valid, in_r, in_i, tw_r, tw_i,
      input  tw_idx, out_valid, out_r, out_i
   );

   modport slave (
      input  in_valid, in_r, in_i, tw_r, tw_i,
      output tw_idx, out_valid, out_r, out_i
   );
endinterface

// File: rtl/sdf_butterfly_stage.sv
// Radix-2 single-delay-feedback DIF butterfly stage with external twiddle ROM.
// Define SDF_SAT_EN to saturate every narrowing to WIDTH instead of wrapping.
module sdf_butterfly_stage #(
   parameter int WIDTH = 17,
   parameter int DEPTH = 16,
   parameter int TW_W  = 12
) (
   input logic                 clk,
   input logic                 rst_n,
   sdf_butterfly_stage_if.slave bus
);
   localparam int CW   = $clog2(2 * DEPTH);
   localparam int PW   = WIDTH + TW_W + 2;
   localparam int STEP = 16 / DEPTH;

   logic [CW-1:0]           r_cnt;
   logic                    r_primed;
   logic                    r_out_valid;
   logic signed [WIDTH-1:0] r_out_r;
   logic signed [WIDTH-1:0] r_out_i;
   logic signed [WIDTH-1:0] r_dly_r [DEPTH];
   logic signed [WIDTH-1:0] r_dly_i [DEPTH];

   logic                    w_phase;
   logic                    w_emit;
   logic [CW-1:0]           w_j;
   logic [31:0]             w_tw_prod;
   logic                    w_unused_tw;
   logic signed [PW-1:0]    w_hr, w_hi, w_xr, w_xi, w_cr, w_ci;
   logic signed [PW-1:0]    w_sum_r, w_sum_i, w_dif_r, w_dif_i;
   logic signed [PW-1:0]    w_pr_full, w_pi_full, w_pr, w_pi;
   logic signed [WIDTH-1:0] w_nsum_r, w_nsum_i, w_ndif_r, w_ndif_i, w_npr, w_npi;

   assign w_phase     = r_cnt[CW-1];
   assign w_j         = r_cnt & CW'(DEPTH - 1);
   assign w_tw_prod   = 32'(w_j) * 32'(STEP);
   assign w_unused_tw = ^w_tw_prod[31:4];
   assign bus.tw_idx  = (bus.in_valid && !w_phase) ? w_tw_prod[3:0] : 4'd0;
   assign w_emit      = bus.in_valid & (w_phase | r_primed);

   // All arithmetic runs at PW bits, wide enough that no intermediate overflows.
   assign w_hr = {{(PW-WIDTH){r_dly_r[DEPTH-1][WIDTH-1]}}, r_dly_r[DEPTH-1]};
   assign w_hi = {{(PW-WIDTH){r_dly_i[DEPTH-1][WIDTH-1]}}, r_dly_i[DEPTH-1]};
   assign w_xr = {{(PW-WIDTH){bus.in_r[WIDTH-1]}}, bus.in_r};
   assign w_xi = {{(PW-WIDTH){bus.in_i[WIDTH-1]}}, bus.in_i};
   assign w_cr = {{(PW-TW_W){bus.tw_r[TW_W-1]}}, bus.tw_r};
   assign w_ci = {{(PW-TW_W){bus.tw_i[TW_W-1]}}, bus.tw_i};

   assign w_sum_r   = w_hr + w_xr;
   assign w_sum_i   = w_hi + w_xi;
   assign w_dif_r   = w_hr - w_xr;
   assign w_dif_i   = w_hi - w_xi;
   assign w_pr_full = w_hr * w_cr - w_hi * w_ci;
   assign w_pi_full = w_hr * w_ci + w_hi * w_cr;
   assign w_pr      = w_pr_full >>> 10;
   assign w_pi      = w_pi_full >>> 10;

`ifdef SDF_SAT_EN
   localparam logic signed [PW-1:0] SAT_MAX = PW'((1 << (WIDTH - 1)) - 1);
   localparam logic signed [PW-1:0] SAT_MIN = ~SAT_MAX;

   function automatic logic signed [WIDTH-1:0] f_sat(input logic signed [PW-1:0] v);
      if (v > SAT_MAX)      return SAT_MAX[WIDTH-1:0];
      else if (v < SAT_MIN) return SAT_MIN[WIDTH-1:0];
      else                  return v[WIDTH-1:0];
   endfunction

   assign w_nsum_r = f_sat(w_sum_r);
   assign w_nsum_i = f_sat(w_sum_i);
   assign w_ndif_r = f_sat(w_dif_r);
   assign w_ndif_i = f_sat(w_dif_i);
   assign w_npr    = f_sat(w_pr);
   assign w_npi    = f_sat(w_pi);
`else
   logic w_unused_hi;

   assign w_nsum_r    = w_sum_r[WIDTH-1:0];
   assign w_nsum_i    = w_sum_i[WIDTH-1:0];
   assign w_ndif_r    = w_dif_r[WIDTH-1:0];
   assign w_ndif_i    = w_dif_i[WIDTH-1:0];
   assign w_npr       = w_pr[WIDTH-1:0];
   assign w_npi       = w_pi[WIDTH-1:0];
   assign w_unused_hi = ^{w_sum_r[PW-1:WIDTH], w_sum_i[PW-1:WIDTH],
                          w_dif_r[PW-1:WIDTH], w_dif_i[PW-1:WIDTH],
                          w_pr[PW-1:WIDTH], w_pi[PW-1:WIDTH]};
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt       <= '0;
         r_primed    <= 1'b0;
         r_out_valid <= 1'b0;
         r_out_r     <= '0;
         r_out_i     <= '0;
      end else begin
         r_out_valid <= w_emit;
         if (bus.in_valid) begin
            r_cnt <= r_cnt + CW'(1);
            if (w_phase) r_primed <= 1'b1;
         end
         // Data registers only move on emitted samples, so stale delay-line
         // contents never reach the output.
         if (w_emit) begin
            r_out_r <= w_phase ? w_nsum_r : w_npr;
            r_out_i <= w_phase ? w_nsum_i : w_npi;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (bus.in_valid) begin
         r_dly_r[0] <= w_phase ? w_ndif_r : bus.in_r;
         r_dly_i[0] <= w_phase ? w_ndif_i : bus.in_i;
         for (int k = 1; k < DEPTH; k++) begin
            r_dly_r[k] <= r_dly_r[k-1];
            r_dly_i[k] <= r_dly_i[k-1];
         end
      end
   end

   assign bus.out_valid = r_out_valid;
   assign bus.out_r     = r_out_r;
   assign bus.out_i     = r_out_i;
endmodule
